apb_requester_bridge: RTL and testbench

APB_REQUESTER_BRIDGE -- requirements
Module: apb_requester_bridge

---
 rtl/apb_pkg.sv | 32 +++
 rtl/apb_requester_bridge_if.sv | 45 ++++
 rtl/apb_requester_bridge_watchdog.sv | 36 +++
 rtl/apb_requester_bridge.sv | 133 +++++++++++++
 tb/tb_apb_requester_bridge.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_pkg.sv
// ----------------------------------------------------------------------------
// apb_pkg
// Shared definitions for the APB requester bridge:
//   - apb_req_state_t : bridge FSM states (IDLE, SETUP, ACCESS, RESP), encoded
//                       through plain localparam constants so that older code
//                       comparing against raw 2-bit values keeps working.
//   - PPROT_*         : pprot bit masks (privileged, non-secure, instruction).
//   - is_busy()       : true whenever a transfer or its response is in flight.
// ----------------------------------------------------------------------------
package apb_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE   = ST_IDLE,
        S_SETUP  = ST_SETUP,
        S_ACCESS = ST_ACCESS,
        S_RESP   = ST_RESP
    } apb_req_state_t;

    localparam logic [2:0] PPROT_PRIV      = 3'b001;
    localparam logic [2:0] PPROT_NONSECURE = 3'b010;
    localparam logic [2:0] PPROT_INSN      = 3'b100;

    function automatic logic is_busy(input apb_req_state_t s);
        return s != S_IDLE;
    endfunction

endpackage

// File: rtl/apb_requester_bridge_if.sv
// ----------------------------------------------------------------------------
// apb_if
// APB4/APB5 bus bundle between one requester and one completer.
// Interface ports : pclk, preset_n (the bus clock and reset, shared with the
//                   requester's own clock/reset).
// Requester drives: paddr, psel, penable, pwrite, pwdata, pstrb, pprot,
//                   pwakeup, pauser, pwuser.
// Completer drives: prdata, pready, pslverr, pruser, pbuser.
// Modports        : requester, completer.
// ----------------------------------------------------------------------------
interface apb_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) (
    input logic pclk,
    input logic preset_n
);
    logic [ADDR_WIDTH-1:0]   paddr;
    logic                    psel;
    logic                    penable;
    logic                    pwrite;
    logic [DATA_WIDTH-1:0]   pwdata;
    logic [DATA_WIDTH/8-1:0] pstrb;
    logic [2:0]              pprot;
    logic                    pwakeup;
    logic                    pauser;
    logic                    pwuser;
    logic [DATA_WIDTH-1:0]   prdata;
    logic                    pready;
    logic                    pslverr;
    logic                    pruser;
    logic                    pbuser;

    modport requester (
        input  pclk, preset_n, prdata, pready, pslverr, pruser, pbuser,
        output paddr, psel, penable, pwrite, pwdata, pstrb, pprot,
               pwakeup, pauser, pwuser
    );

    modport completer (
        input  pclk, preset_n, paddr, psel, penable, pwrite, pwdata, pstrb,
               pprot, pwakeup, pauser, pwuser,
        output prdata, pready, pslverr, pruser, pbuser
    );
endinterface

// File: rtl/apb_requester_bridge_watchdog.sv
// ----------------------------------------------------------------------------
// apb_watchdog_counter
// Counts ACCESS-phase wait cycles and flags the cycle on which the limit is
// reached. Only instantiated when APB_REQUESTER_TIMEOUT_EN is defined.
// Ports:
//   clk       : clock
//   srst_n    : synchronous active-low reset
//   i_clear   : restart the count (asserted the cycle before ACCESS begins)
//   i_tick    : one more ACCESS cycle without pready
//   o_expired : this tick is the LIMIT-th one; abort the transfer
// ----------------------------------------------------------------------------
module apb_watchdog_counter #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic srst_n,
    input  logic i_clear,
    input  logic i_tick,
    output logic o_expired
);
    logic [15:0] r_count;

    always_ff @(posedge clk) begin
        if (!srst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_tick) begin
            r_count <= r_count + 16'd1;
        end
    end

    // r_count holds the wait cycles already seen, so the current tick is the
    // LIMIT-th one when r_count equals LIMIT-1.
    assign o_expired = i_tick && (r_count == 16'(LIMIT - 1));
endmodule

// File: rtl/apb_requester_bridge.sv
// ----------------------------------------------------------------------------
// apb_requester_bridge
// Turns a valid/ready command into a single APB transfer and returns the
// result on a valid/ready response channel. One transfer in flight at a time.
// Optional macro: APB_REQUESTER_TIMEOUT_EN -- abort ACCESS after
// TIMEOUT_CYCLES cycles without pready (response flagged as error).
// Ports:
//   pclk, preset_n          : clock, synchronous active-low reset
//   cmd_valid / cmd_ready   : command handshake (ready only in IDLE)
//   cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot : command fields
//   rsp_valid / rsp_ready   : response handshake
//   rsp_rdata, rsp_err      : read data (0 for writes/aborts), error flag
//   apb                     : APB bus, requester side
// ----------------------------------------------------------------------------
module apb_requester_bridge
    import apb_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    pclk,
    input  logic                    preset_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_strb,
    input  logic [2:0]              cmd_prot,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    apb_if.requester                apb
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    apb_req_state_t          r_state;
    apb_req_state_t          w_state_next;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic                    r_write;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [STRB_WIDTH-1:0]   r_strb;
    logic [2:0]              r_prot;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic                    r_err;
    logic                    w_accept;
    logic                    w_done;
    logic                    w_timeout;

`ifdef APB_REQUESTER_TIMEOUT_EN
    apb_watchdog_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (pclk),
        .srst_n    (preset_n),
        .i_clear   (r_state == S_SETUP),
        .i_tick    ((r_state == S_ACCESS) && !apb.pready),
        .o_expired (w_timeout)
    );
`else
    assign w_timeout = 1'b0;
`endif

    // Completer and user sideband inputs this bridge never consumes.
    logic w_unused_inputs;
    assign w_unused_inputs = ^{apb.pruser, apb.pbuser, apb.pclk, apb.preset_n,
                               16'(TIMEOUT_CYCLES)};

    // Gating with preset_n keeps the handshake closed during reset even
    // though the state register only settles at the reset edge.
    assign cmd_ready = preset_n && (r_state == S_IDLE);
    assign w_accept  = cmd_valid && cmd_ready;
    // pready wins over a timeout on the same cycle (w_timeout needs !pready).
    assign w_done    = (r_state == S_ACCESS) && apb.pready;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (w_accept)            w_state_next = S_SETUP;
            S_SETUP:                           w_state_next = S_ACCESS;
            S_ACCESS: if (w_done || w_timeout) w_state_next = S_RESP;
            S_RESP:   if (rsp_ready)           w_state_next = S_IDLE;
            default:                           w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (!preset_n) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_write <= 1'b0;
            r_wdata <= '0;
            r_strb  <= '0;
            r_prot  <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_addr  <= cmd_addr;
                r_write <= cmd_write;
                // Reads put zero on pwdata/pstrb, so mask at capture time.
                r_wdata <= cmd_write ? cmd_wdata : '0;
                r_strb  <= cmd_write ? cmd_strb  : '0;
                r_prot  <= cmd_prot;
            end
            if (w_done) begin
                r_rdata <= r_write ? '0 : apb.prdata;
                r_err   <= apb.pslverr;
            end else if (w_timeout) begin
                r_rdata <= '0;
                r_err   <= 1'b1;
            end
        end
    end

    assign apb.psel    = (r_state == S_SETUP) || (r_state == S_ACCESS);
    assign apb.penable = (r_state == S_ACCESS);
    assign apb.paddr   = r_addr;
    assign apb.pwrite  = r_write;
    assign apb.pwdata  = r_wdata;
    assign apb.pstrb   = r_strb;
    assign apb.pprot   = r_prot;
    assign apb.pwakeup = preset_n && (is_busy(r_state) || cmd_valid);
    assign apb.pauser  = 1'b0;
    assign apb.pwuser  = 1'b0;

    assign rsp_valid = (r_state == S_RESP);
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;
endmodule

// File: tb/tb_apb_requester_bridge.sv
// ----------------------------------------------------------------------------
// tb_apb_requester_bridge
// Transaction-level bench: each transfer is described by its command fields,
// the completer's wait states / error / read data, and the response
// back-pressure. Expected per-cycle bus and response values follow from the
// transfer timeline (accept, one SETUP, ACCESS wait states, RESP hold).
// ----------------------------------------------------------------------------
module tb_apb_requester_bridge;
    import apb_pkg::*;

    localparam int DW = 32;
    localparam int AW = 16;
    localparam int SW = DW / 8;
    localparam int TO = 8;
`ifdef APB_REQUESTER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    localparam int PH_IDLE   = 0;
    localparam int PH_ACCEPT = 1;
    localparam int PH_SETUP  = 2;
    localparam int PH_ACCESS = 3;
    localparam int PH_RESP   = 4;

    typedef struct {
        bit            write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] strb;
        logic [2:0]    prot;
        int            wait_states;
        bit            err;
        logic [DW-1:0] rdata;
        int            hold;
    } txn_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [SW-1:0] cmd_strb;
    logic [2:0]    cmd_prot;
    logic          rsp_valid, rsp_ready, rsp_err;
    logic [DW-1:0] rsp_rdata;

    always #5 clk = ~clk;

    apb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) apb (.pclk(clk), .preset_n(rst_n));

    apb_requester_bridge #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .pclk(clk), .preset_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .cmd_prot(cmd_prot), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .apb(apb)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Observations of the last transfer, checked against hand-computed values.
    int            obs_access, obs_lat, obs_resp, obs_rdy_in_resp;
    logic [DW-1:0] obs_rdata;
    logic          obs_err;
    logic [SW-1:0] obs_pstrb;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic noise();
        apb.pready  = 1'($urandom);
        apb.pslverr = 1'($urandom);
        apb.prdata  = $urandom;
        cmd_write   = 1'($urandom);
        cmd_addr    = AW'($urandom);
        cmd_wdata   = $urandom;
        cmd_strb    = SW'($urandom);
        cmd_prot    = 3'($urandom);
    endtask

    task automatic check_cycle(input int ph, input txn_t t, input bit to);
        chk("cmd_ready", cmd_ready, (ph == PH_IDLE) || (ph == PH_ACCEPT));
        chk("psel", apb.psel, (ph == PH_SETUP) || (ph == PH_ACCESS));
        chk("penable", apb.penable, ph == PH_ACCESS);
        chk("rsp_valid", rsp_valid, ph == PH_RESP);
        chk("pwakeup", apb.pwakeup, ph != PH_IDLE);
        chk("user", {apb.pauser, apb.pwuser}, 0);
        if ((ph == PH_SETUP) || (ph == PH_ACCESS)) begin
            chk("paddr", apb.paddr, t.addr);
            chk("pwrite", apb.pwrite, t.write);
            chk("pwdata", apb.pwdata, t.write ? t.wdata : '0);
            chk("pstrb", apb.pstrb, t.write ? t.strb : '0);
            chk("pprot", apb.pprot, t.prot);
        end
        if (ph == PH_RESP) begin
            chk("rsp_rdata", rsp_rdata, (to || t.write) ? '0 : t.rdata);
            chk("rsp_err", rsp_err, to || t.err);
        end
    endtask

    task automatic observe(input int idx);
        if (apb.psel && apb.penable) begin
            obs_access++;
            obs_pstrb = obs_pstrb | apb.pstrb;
        end
        if (rsp_valid) begin
            if (obs_lat < 0) obs_lat = idx;
            obs_rdata = rsp_rdata;
            obs_err   = rsp_err;
            obs_resp++;
            if (cmd_ready) obs_rdy_in_resp++;
        end
    endtask

    // Accept cycle, SETUP and the first n_access ACCESS cycles of t.
    task automatic start_txn(input txn_t t, input int n_access, input bit to);
        int idx;
        idx = 0;
        @(posedge clk); #1;
        noise();
        cmd_valid = 1'b1; cmd_write = t.write; cmd_addr = t.addr;
        cmd_wdata = t.wdata; cmd_strb = t.strb; cmd_prot = t.prot;
        rsp_ready = 1'($urandom);
        @(negedge clk); check_cycle(PH_ACCEPT, t, to); observe(idx++);
        @(posedge clk); #1;
        noise(); cmd_valid = 1'($urandom); rsp_ready = 1'($urandom);
        @(negedge clk); check_cycle(PH_SETUP, t, to); observe(idx++);
        for (int n = 1; n <= n_access; n++) begin
            @(posedge clk); #1;
            noise(); cmd_valid = 1'($urandom); rsp_ready = 1'($urandom);
            apb.pready = (n == t.wait_states + 1);
            if (apb.pready) begin
                apb.pslverr = t.err;
                apb.prdata  = t.rdata;
            end
            @(negedge clk); check_cycle(PH_ACCESS, t, to); observe(idx++);
        end
    endtask

    task automatic do_txn(input txn_t t, input int gap);
        bit to;
        int n_access, idx;
        to       = TO_EN && (t.wait_states >= TO);
        n_access = to ? TO : t.wait_states + 1;
        obs_access = 0; obs_lat = -1; obs_resp = 0; obs_rdy_in_resp = 0;
        obs_pstrb = '0; obs_rdata = 'x; obs_err = 1'bx;
        for (int i = 0; i < gap; i++) begin
            @(posedge clk); #1;
            noise(); cmd_valid = 1'b0; rsp_ready = 1'($urandom);
            @(negedge clk); check_cycle(PH_IDLE, t, to);
        end
        start_txn(t, n_access, to);
        idx = n_access + 2;
        for (int m = 1; m <= t.hold + 1; m++) begin
            @(posedge clk); #1;
            noise(); cmd_valid = 1'($urandom);
            rsp_ready = (m == t.hold + 1);
            @(negedge clk); check_cycle(PH_RESP, t, to); observe(idx++);
        end
        $display("txn %s addr=%h wait=%0d hold=%0d rdata=%h err=%0d",
                 t.write ? "WR" : "RD", t.addr, t.wait_states, t.hold, obs_rdata, obs_err);
    endtask

    function automatic txn_t mk(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                                input logic [SW-1:0] s, input logic [2:0] p, input int ws,
                                input bit e, input logic [DW-1:0] rd, input int h);
        txn_t t;
        t.write = w; t.addr = a; t.wdata = wd; t.strb = s; t.prot = p;
        t.wait_states = ws; t.err = e; t.rdata = rd; t.hold = h;
        return t;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        txn_t t;
        rst_n = 1'b0; rsp_ready = 1'b0; cmd_valid = 1'b1;
        noise();
        apb.pruser = 1'b0; apb.pbuser = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst cmd_ready", cmd_ready, 0);
        chk("rst psel", apb.psel, 0);
        chk("rst penable", apb.penable, 0);
        chk("rst pwrite", apb.pwrite, 0);
        chk("rst pwakeup", apb.pwakeup, 0);
        chk("rst rsp_valid", rsp_valid, 0);
        chk("rst rsp_err", rsp_err, 0);
        chk("rst paddr", apb.paddr, 0);
        chk("rst pwdata", apb.pwdata, 0);
        chk("rst pstrb", apb.pstrb, 0);
        chk("rst pprot", apb.pprot, 0);
        chk("rst rsp_rdata", rsp_rdata, 0);
        @(posedge clk); #1;
        rst_n = 1'b1; cmd_valid = 1'b0;

        // Zero-wait write.
        do_txn(mk(1'b1, 16'h0040, 32'hDEADBEEF, 4'hF, PPROT_PRIV, 0, 1'b0, 32'hAAAA5555, 0), 1);
        chk("wr latency", obs_lat, 3);
        chk("wr access cycles", obs_access, 1);
        chk("wr rsp_rdata", obs_rdata, 32'h0);
        chk("wr rsp_err", obs_err, 1'b0);

        // Read with three wait states, back-to-back with the write.
        do_txn(mk(1'b0, 16'h0100, 32'hFFFFFFFF, 4'hF, PPROT_NONSECURE, 3, 1'b0, 32'h12345678, 0), 0);
        chk("rd access cycles", obs_access, 4);
        chk("rd rsp_rdata", obs_rdata, 32'h12345678);
        chk("rd pstrb", obs_pstrb, 4'h0);
        chk("rd latency", obs_lat, 6);

        // Read error with response held off for five cycles.
        do_txn(mk(1'b0, 16'h0200, 32'h0, 4'h0, PPROT_INSN, 1, 1'b1, 32'h0BADF00D, 5), 2);
        chk("err rsp_err", obs_err, 1'b1);
        chk("err resp cycles", obs_resp, 6);
        chk("err cmd_ready in resp", obs_rdy_in_resp, 0);

`ifdef APB_REQUESTER_TIMEOUT_EN
        do_txn(mk(1'b0, 16'h0300, 32'h0, 4'h0, 3'b000, 100, 1'b0, 32'h11111111, 0), 1);
        chk("timeout access cycles", obs_access, 8);
        chk("timeout rsp_err", obs_err, 1'b1);
        chk("timeout rsp_rdata", obs_rdata, 32'h0);
        do_txn(mk(1'b0, 16'h0304, 32'h0, 4'h0, 3'b000, 7, 1'b0, 32'hCAFEF00D, 0), 1);
        chk("late ready access cycles", obs_access, 8);
        chk("late ready rsp_err", obs_err, 1'b0);
        chk("late ready rsp_rdata", obs_rdata, 32'hCAFEF00D);
`endif

        // Reset in the middle of ACCESS.
        t = mk(1'b1, 16'h0500, 32'h5A5A5A5A, 4'h3, 3'b000, 20, 1'b0, 32'h0, 0);
        @(posedge clk); #1; cmd_valid = 1'b0;
        start_txn(t, 1, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0; cmd_valid = 1'b1; apb.pready = 1'b0;
        @(negedge clk);
        chk("in-reset cmd_ready", cmd_ready, 0);
        chk("in-reset pwakeup", apb.pwakeup, 0);
        @(posedge clk); #1;
        rst_n = 1'b1; cmd_valid = 1'b0; apb.pready = 1'b1;
        @(negedge clk);
        chk("post-reset psel", apb.psel, 0);
        chk("post-reset penable", apb.penable, 0);
        chk("post-reset rsp_valid", rsp_valid, 0);
        chk("post-reset paddr", apb.paddr, 0);
        chk("post-reset cmd_ready", cmd_ready, 1);
        do_txn(mk(1'b0, 16'h0600, 32'h0, 4'h0, 3'b011, 2, 1'b0, 32'h87654321, 1), 3);
        chk("after-reset rsp_rdata", obs_rdata, 32'h87654321);
        chk("after-reset access cycles", obs_access, 3);

        // Randomized traffic.
        for (int i = 0; i < 60; i++) begin
            t = mk(1'($urandom), AW'($urandom), $urandom, SW'($urandom), 3'($urandom),
                   $urandom_range(0, TO_EN ? 10 : 5), 1'($urandom), $urandom,
                   $urandom_range(0, 3));
            do_txn(t, $urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
